// File: rtl/hdb3_tx_sequencer.sv
// hdb3_tx_sequencer: serialises framed bytes MSB-first into the HDB3 encoder,
// appends flush zeros and drains, and tags which encoder output symbols carry payload.
module hdb3_tx_sequencer #(
  parameter int DATA_W     = 8,
  parameter int PIPE_LAT   = 5,
  parameter int FLUSH_BITS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              enc_din,
  output logic              tag_valid,
  output logic              tag_last,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [2:0] {IDLE, SHIFT, WAIT, FLUSH, DRAIN} state_t;
  state_t                   state_q, state_d;
  logic [DATA_W-1:0]        sh_q, sh_d;
  logic [CW-1:0]            bit_cnt_q, bit_cnt_d;
  logic                     last_flag_q, last_flag_d;
  logic [3:0]               flush_cnt_q, flush_cnt_d, drain_cnt_q, drain_cnt_d;
  logic                     enc_din_q, enc_din_d, frame_done_q, frame_done_d, underrun_q, underrun_d;
  logic [1:0]               tag_q, tag_d;
  logic [PIPE_LAT-1:0][1:0] pipe_q, pipe_d;
  logic                     xfer;
  assign s_ready = reset_n && enable && (state_q == IDLE || state_q == WAIT ||
                   (state_q == SHIFT && bit_cnt_q == '0 && !last_flag_q));
  assign xfer       = s_valid && s_ready;
  assign enc_din    = enc_din_q;
  assign tag_valid  = pipe_q[PIPE_LAT-1][1];
  assign tag_last   = pipe_q[PIPE_LAT-1][0];
  assign busy       = state_q != IDLE;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    bit_cnt_d    = bit_cnt_q;
    last_flag_d  = last_flag_q;
    flush_cnt_d  = flush_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    enc_din_d    = 1'b0;
    tag_d        = 2'b00;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    pipe_d       = pipe_q << 2;
    pipe_d[0]    = tag_q;
    case (state_q)
      IDLE, WAIT: ;
      SHIFT: begin
        enc_din_d = sh_q[DATA_W-1];
        tag_d     = {1'b1, last_flag_q && bit_cnt_q == '0};
        sh_d      = sh_q << 1;
        bit_cnt_d = bit_cnt_q - 1'b1;
        if (bit_cnt_q == '0 && last_flag_q) begin
          state_d     = FLUSH;
          flush_cnt_d = 4'(FLUSH_BITS - 1);
        end else if (bit_cnt_q == '0 && !xfer) begin
          state_d    = WAIT;
          underrun_d = 1'b1;
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q - 1'b1;
        if (flush_cnt_q == '0) begin
          state_d     = DRAIN;
          drain_cnt_d = 4'(PIPE_LAT - 1);
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q - 1'b1;
        if (drain_cnt_q == '0) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // s_ready already restricts acceptance to IDLE, WAIT and the final SHIFT bit
    if (xfer) begin
      state_d     = SHIFT;
      sh_d        = s_data;
      bit_cnt_d   = CW'(DATA_W - 1);
      last_flag_d = s_last;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      last_flag_q  <= 1'b0;
      flush_cnt_q  <= '0;
      drain_cnt_q  <= '0;
      enc_din_q    <= 1'b0;
      tag_q        <= 2'b00;
      pipe_q       <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      last_flag_q  <= last_flag_d;
      flush_cnt_q  <= flush_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      enc_din_q    <= enc_din_d;
      tag_q        <= tag_d;
      pipe_q       <= pipe_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end
endmodule

// File: tb/tb_hdb3_tx_sequencer.sv
// tb_hdb3_tx_sequencer: directed frames plus randomized traffic against a queue-based
// reference of the bit stream, tag delay line and frame tail.
module tb_hdb3_tx_sequencer;
  localparam int DW = 8, PL = 5, FB = 4;
  logic clk = 1'b0;
  logic reset_n, enable, s_valid, s_last;
  logic [DW-1:0] s_data;
  logic s_ready, enc_din, tag_valid, tag_last, busy, frame_done, underrun;
  int n_vec = 0, n_err = 0;

  hdb3_tx_sequencer #(.DATA_W(DW), .PIPE_LAT(PL), .FLUSH_BITS(FB)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .enc_din(enc_din), .tag_valid(tag_valid),
    .tag_last(tag_last), .busy(busy), .frame_done(frame_done), .underrun(underrun));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: pending line bits of the current word, remaining tail cycles, tag history.
  bit       mq[$];
  bit [1:0] thist[$];
  bit       m_last, m_busy, m_enc, m_tv, m_tl, m_done, m_ur, m_xfer;
  int       m_tail;

  function automatic bit exp_ready();
    return reset_n && enable &&
           (!m_busy || (m_tail == 0 && (mq.size() == 0 || (mq.size() == 1 && !m_last))));
  endfunction

  function automatic void model_reset();
    mq.delete();
    thist.delete();
    repeat (PL) thist.push_back(2'b00);
    {m_last, m_busy, m_enc, m_tv, m_tl, m_done, m_ur, m_xfer} = '0;
    m_tail = 0;
  endfunction

  function automatic void model_edge();
    bit [1:0] t = 2'b00;
    m_xfer = s_valid && exp_ready();
    {m_enc, m_done, m_ur} = '0;
    if (m_tail > 0) begin
      m_tail--;
      if (m_tail == 0) begin
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end else if (mq.size() > 0) begin
      m_enc = mq.pop_front();
      t = {1'b1, m_last && mq.size() == 0};
      if (mq.size() == 0 && m_last) m_tail = FB + PL;
      else if (mq.size() == 0 && !m_xfer) m_ur = 1'b1;
    end
    if (m_xfer) begin
      for (int i = DW - 1; i >= 0; i--) mq.push_back(s_data[i]);
      m_last = s_last;
      m_busy = 1'b1;
    end
    {m_tv, m_tl} = thist.pop_front();
    thist.push_back(t);
  endfunction

  task automatic check_outs();
    chk("enc_din", enc_din, m_enc);
    chk("tag_valid", tag_valid, m_tv);
    chk("tag_last", tag_last, m_tl);
    chk("busy", busy, m_busy);
    chk("frame_done", frame_done, m_done);
    chk("underrun", underrun, m_ur);
  endtask

  bit acc;
  task automatic cycle();
    #1;
    chk("s_ready", s_ready, exp_ready());
    acc = s_valid && s_ready;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    chk("s_ready_in_reset", s_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [8:0] wq[$];
  int n_acc, acc0, acc1, n_tv, n_tl, n_ur, n_fd, tv_first, tv_last, tl_c, fd_c, zeros;
  logic [7:0] rx;

  task automatic run_frame(input int ncyc, input int late, input int en_off);
    int idx = 0;
    n_acc = 0; acc0 = -100; acc1 = -100; n_tv = 0; n_tl = 0; n_ur = 0; n_fd = 0;
    tv_first = -1; tv_last = -1; tl_c = -1; fd_c = -1; zeros = 0; rx = '0;
    for (int c = 0; c < ncyc; c++) begin
      enable  = !(en_off >= 0 && c >= en_off && c < en_off + 10);
      s_valid = idx < wq.size() && !(idx == 1 && late > 0 && c < acc0 + DW + late);
      s_data  = idx < wq.size() ? wq[idx][7:0] : '0;
      s_last  = idx < wq.size() && wq[idx][8];
      cycle();
      if (acc) begin
        if (n_acc == 0) acc0 = c;
        else if (n_acc == 1) acc1 = c;
        n_acc++;
      end
      if (m_xfer) idx++;
      if (acc0 >= 0 && c > acc0 && c <= acc0 + DW) rx = {rx[6:0], enc_din};
      if (acc0 >= 0 && c > acc0 + DW && c <= acc0 + DW + FB && !enc_din) zeros++;
      if (tag_valid) begin
        n_tv++;
        if (tv_first < 0) tv_first = c;
        tv_last = c;
      end
      if (tag_last) begin
        n_tl++;
        tl_c = c;
      end
      if (underrun) n_ur++;
      if (frame_done) begin
        n_fd++;
        fd_c = c;
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    bit pend = 1'b0, plst = 1'b0;
    logic [7:0] pd = '0;
    int cnt;
    reset_n = 1'b0; enable = 1'b1; s_valid = 1'b1; s_data = 8'h3C; s_last = 1'b0;
    model_reset();
    #3;
    check_outs();
    chk("s_ready_in_reset", s_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    s_valid = 1'b0;

    wq = '{{1'b1, 8'hA5}};
    run_frame(22, 0, -1);
    chk("a5_bits", rx, 8'hA5);
    chk("a5_flush_zeros", zeros, FB);
    chk("a5_tag_start", tv_first - acc0, 1 + PL);
    chk("a5_tag_count", n_tv, DW);
    chk("a5_tag_last_pos", tl_c - acc0, DW + PL);
    chk("a5_done_pos", fd_c - acc0, 17);

    wq = '{{1'b0, 8'hFF}, {1'b0, 8'h00}, {1'b1, 8'h81}};
    run_frame(38, 0, -1);
    chk("w3_accepts", n_acc, 3);
    chk("w3_tag_count", n_tv, 3 * DW);
    chk("w3_contiguous", tv_last - tv_first + 1, 3 * DW);
    chk("w3_one_last", n_tl, 1);
    chk("w3_last_at_end", tl_c, tv_last);
    chk("w3_no_underrun", n_ur, 0);

    wq = '{{1'b0, 8'h3C}, {1'b1, 8'hC3}};
    run_frame(34, 3, -1);
    chk("late_underrun", n_ur, 1);
    chk("late_tag_count", n_tv, 2 * DW);
    chk("late_gap", tv_last - tv_first + 1 - n_tv, 3);
    chk("late_one_last", n_tl, 1);

    wq = '{{1'b0, 8'h5A}, {1'b1, 8'h96}};
    run_frame(34, 0, 2);
    chk("en_underrun", n_ur, 1);
    chk("en_tag_count", n_tv, 2 * DW);
    chk("en_second_accept", acc1, 12);
    chk("en_done", n_fd, 1);

    wq = '{{1'b1, 8'h12}, {1'b1, 8'h34}};
    run_frame(40, 0, -1);
    chk("b2b_accept_gap", acc1 - acc0, 18);
    chk("b2b_done", n_fd, 2);

    enable = 1'b1; s_valid = 1'b1; s_data = 8'hE7; s_last = 1'b0;
    cycle();
    s_valid = 1'b0;
    repeat (5) cycle();
    async_reset();
    cnt = 0;
    repeat (PL + 2) begin
      cycle();
      if (tag_valid || tag_last) cnt++;
    end
    chk("no_stale_tags", cnt, 0);

    for (int c = 0; c < 4000; c++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        pd   = 8'($urandom);
        plst = $urandom_range(0, 3) == 0;
      end
      enable  = $urandom_range(0, 15) != 0;
      s_valid = pend;
      s_data  = pd;
      s_last  = plst;
      cycle();
      if (m_xfer) pend = 1'b0;
      if ($urandom_range(0, 799) == 0) begin
        async_reset();
        pend = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
